// File: rtl/case9_pkg.sv
// Shared types and constants for the case9 round-robin scheduler.
// Operand field order is {a,b,c,d,e,f,g,h,i,j}, with a at the MSB.
package case9_pkg;

    localparam int OP_W  = 10;
    localparam int RES_W = 5;

    localparam int IDX_A = 9;
    localparam int IDX_B = 8;
    localparam int IDX_C = 7;
    localparam int IDX_D = 6;
    localparam int IDX_E = 5;
    localparam int IDX_F = 4;
    localparam int IDX_G = 3;
    localparam int IDX_H = 2;
    localparam int IDX_I = 1;
    localparam int IDX_J = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/case9_eval.sv
// Combinational case9 evaluator: 10-bit operand in, 5-bit result {y5,y4,y3,y2,y1} out.
// Purely combinational; no state and no flow control.
module case9_eval
    import case9_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    output logic [RES_W-1:0] y
);

    logic a, b, c, d, e, f, g, h, i, j;
    logic q, s, p, t;
    logic y1, y2, y3, y4, y5;

    assign a = op[IDX_A];
    assign b = op[IDX_B];
    assign c = op[IDX_C];
    assign d = op[IDX_D];
    assign e = op[IDX_E];
    assign f = op[IDX_F];
    assign g = op[IDX_G];
    assign h = op[IDX_H];
    assign i = op[IDX_I];
    assign j = op[IDX_J];

    assign q  = (a & b) | (~c & ~d);
    assign s  = g & h & (e ^ f);
    assign p  = i | j;
    assign t  = ~p | s;

    assign y1 = s & q;
    assign y2 = (p ~^ q) | s;
    assign y5 = y2;
    assign y3 = t ~^ ~q;
    assign y4 = t & (p | ~q);

    assign y = {y5, y4, y3, y2, y1};

endmodule

// File: rtl/case9_sched.sv
// Round-robin scheduler sharing one case9 evaluator among NREQ requesters.
// Grant in IDLE, evaluate in EVAL, hold the result in RESP until the consumer accepts it.
module case9_sched
    import case9_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int ID_W  = $clog2(NREQ),
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*OP_W-1:0] req_vec,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [RES_W-1:0]     rsp_y,
    output logic                 busy,
    output logic [CNT_W-1:0]     eval_cnt
);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [RES_W-1:0]   rsp_y_q, rsp_y_d;
    logic [CNT_W-1:0]   eval_cnt_q, eval_cnt_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;
    logic [RES_W-1:0]   eval_y;

    case9_eval u_eval (
        .op (op_q),
        .y  (eval_y)
    );

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_found) state_d = EVAL;
            EVAL:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant is gated by rst_n so no requester sees an accept while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
        busy = (state_q != IDLE);
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        grant_id_d  = grant_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        eval_cnt_d  = eval_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_d       = req_vec[int'(grant_idx)*OP_W +: OP_W];
                    grant_id_d = grant_idx;
                    rr_ptr_d   = (grant_idx == ID_W'(NREQ - 1)) ? '0
                                                                : grant_idx + ID_W'(1);
                end
            end
            EVAL: begin
                rsp_y_d     = eval_y;
                rsp_id_d    = grant_id_q;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    eval_cnt_d  = eval_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            op_q        <= '0;
            grant_id_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
            eval_cnt_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            grant_id_q  <= grant_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            eval_cnt_q  <= eval_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign eval_cnt  = eval_cnt_q;

endmodule
